// File: rtl/io_event_controller.sv
// io_event_controller: button event flags, status word and output FIFO on the data-memory port
// Optional IO_EVENT_COUNT_EN replaces each event flag with a saturating COUNT_W-bit counter.
module io_event_controller #(
    parameter logic [31:0] ADDR_BTNC  = 32'd1000,
    parameter logic [31:0] ADDR_OUT   = 32'd2000,
    parameter logic [31:0] ADDR_BTNL  = 32'd3000,
    parameter logic [31:0] ADDR_BTNR  = 32'd4000,
    parameter logic [31:0] ADDR_BTNU  = 32'd5000,
    parameter logic [31:0] ADDR_BTND  = 32'd6000,
    parameter logic [31:0] ADDR_STAT  = 32'd2004,
    parameter int          FIFO_DEPTH = 4,
    parameter int          COUNT_W    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  btn_in,
    input  logic [31:0] mem_addr,
    input  logic        mem_wren,
    input  logic        mem_rden,
    input  logic [31:0] mem_wdata,
    output logic        io_hit,
    output logic [31:0] io_rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || COUNT_W < 1 || COUNT_W > 32) begin : g_bad_param
        $error("io_event_controller: invalid FIFO_DEPTH or COUNT_W");
    end

    logic [4:0]    prev, rise, btn_sel, flag_nz;
    logic [31:0]   btn_rd;
    logic          rd, stat_sel, push_req, push, pop, full, ovf;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fifo [FIFO_DEPTH];

    // a simultaneous store wins, so the load strobe is ignored then
    assign rd       = mem_rden & ~mem_wren;
    assign btn_sel  = {5{rd}} & {mem_addr == ADDR_BTND, mem_addr == ADDR_BTNU,
                                 mem_addr == ADDR_BTNR, mem_addr == ADDR_BTNL,
                                 mem_addr == ADDR_BTNC};
    assign stat_sel = rd && mem_addr == ADDR_STAT;
    assign io_hit   = |btn_sel | stat_sel;
    assign rise     = btn_in & ~prev;

    always_ff @(posedge clock or negedge reset)
        if (!reset) prev <= '0;
        else prev <= btn_in;

`ifdef IO_EVENT_COUNT_EN
    logic [4:0][COUNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt <= '0;
        else
            for (int k = 0; k < 5; k++)
                if (btn_sel[k]) cnt[k] <= COUNT_W'(rise[k]);
                else if (rise[k] && !(&cnt[k])) cnt[k] <= cnt[k] + 1'b1;

    always_comb begin
        btn_rd  = '0;
        flag_nz = '0;
        for (int k = 0; k < 5; k++) begin
            flag_nz[k] = |cnt[k];
            btn_rd     = btn_rd | (btn_sel[k] ? 32'(cnt[k]) : 32'd0);
        end
    end
`else
    logic [4:0] flags;

    // a rise in the clearing cycle keeps the flag set
    always_ff @(posedge clock or negedge reset)
        if (!reset) flags <= '0;
        else flags <= rise | (flags & ~btn_sel);

    assign flag_nz = flags;
    assign btn_rd  = {31'b0, |(btn_sel & flags)};
`endif

    assign io_rdata = stat_sel ? {ovf, 15'b0, 8'(count), 3'b0, flag_nz} : btn_rd;

    assign out_valid = count != '0;
    assign out_data  = out_valid ? fifo[rd_ptr] : '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign pop       = out_valid & out_ready;
    assign push_req  = mem_wren && mem_addr == ADDR_OUT;
    assign push      = push_req & (~full | pop);

    always_ff @(posedge clock)
        if (push) fifo[wr_ptr] <= mem_wdata;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            ovf    <= (push_req & ~push) | (ovf & ~stat_sel);
        end
endmodule

// File: tb/tb_io_event_controller.sv
// tb_io_event_controller: vector table for event/status reads, queue scoreboard for the output FIFO
module tb_io_event_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  btn_in = '0;
    logic [31:0] mem_addr = '0;
    logic        mem_wren = 1'b0;
    logic        mem_rden = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        io_hit;
    logic [31:0] io_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb [$];

    typedef struct {
        logic [4:0]  b;
        logic [31:0] a;
        logic        r;
        logic        h;
        logic [31:0] d;
    } vec_t;
    vec_t v [$];

    io_event_controller dut (
        .clock(clock), .reset(reset), .btn_in(btn_in), .mem_addr(mem_addr),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_wdata(mem_wdata),
        .io_hit(io_hit), .io_rdata(io_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // one cycle: drive at negedge, check FIFO output against the scoreboard, then update it
    task automatic cyc(input logic [4:0] b, input logic [31:0] a, input logic r,
                       input logic w, input logic [31:0] d, input logic rdy);
        logic p;
        @(negedge clock);
        btn_in = b; mem_addr = a; mem_rden = r; mem_wren = w; mem_wdata = d; out_ready = rdy;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) chk("out_data", out_data, sb[0]);
        p = sb.size() != 0 && rdy;
        if (w && a == 32'd2000 && (sb.size() < 4 || p)) sb.push_back(d);
        if (p) void'(sb.pop_front());
    endtask

    task automatic rd_chk(input string n, input logic [4:0] b, input logic [31:0] a,
                          input logic rdy, input logic [31:0] exp);
        cyc(b, a, 1'b1, 1'b0, 32'd0, rdy);
        chk({n, "_hit"}, {31'b0, io_hit}, 32'd1);
        chk(n, io_rdata, exp);
    endtask

    task automatic st(input logic [31:0] d, input logic rdy);
        cyc(5'd0, 32'd2000, 1'b0, 1'b1, d, rdy);
    endtask

    initial begin
        v.push_back('{5'b00001, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00001, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00001, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00000, 32'd1000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00000, 32'd1000, 1'b1, 1'b1, 32'h0});
        v.push_back('{5'b00000, 32'd2004, 1'b1, 1'b1, 32'h0});
        v.push_back('{5'b00010, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00000, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00010, 32'd3000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00010, 32'd3000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00000, 32'd3000, 1'b1, 1'b1, 32'h0});
        v.push_back('{5'b11100, 32'd0,    1'b0, 1'b0, 32'h0});
        v.push_back('{5'b00000, 32'd2004, 1'b1, 1'b1, 32'h1C});
        v.push_back('{5'b00000, 32'd4000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00000, 32'd5000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00000, 32'd6000, 1'b1, 1'b1, 32'h1});
        v.push_back('{5'b00000, 32'd2004, 1'b1, 1'b1, 32'h0});
        v.push_back('{5'b00000, 32'd7000, 1'b1, 1'b0, 32'h0});
        v.push_back('{5'b00000, 32'd1004, 1'b1, 1'b0, 32'h0});
        v.push_back('{5'b00000, 32'd1000, 1'b0, 1'b0, 32'h0});

        // reset state, with BTNC held high across the release
        btn_in = 5'b00001; mem_rden = 1'b1; mem_addr = 32'd2004;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_hit", {31'b0, io_hit}, 32'd1);
        chk("rst_status", io_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc(5'b00001, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        rd_chk("held_btn_rd1", 5'b00001, 32'd1000, 1'b0, 32'd1);
        rd_chk("held_btn_rd2", 5'b00001, 32'd1000, 1'b0, 32'd0);
        cyc(5'b00000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        foreach (v[i]) begin
            cyc(v[i].b, v[i].a, v[i].r, 1'b0, 32'd0, 1'b0);
            chk($sformatf("vec%0d_hit", i), {31'b0, io_hit}, {31'b0, v[i].h});
            chk($sformatf("vec%0d_rdata", i), io_rdata, v[i].d);
        end

        // three stores, then drain
        st(32'hA, 1'b0); st(32'hB, 1'b0); st(32'hC, 1'b0);
        rd_chk("stat_cnt3", 5'd0, 32'd2004, 1'b0, 32'h0000_0300);
        repeat (4) cyc(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("drained3", 32'(sb.size()), 32'd0);

        // overflow: fifth word dropped
        for (int i = 0; i < 5; i++) st(32'h100 + i, 1'b0);
        rd_chk("stat_ovf", 5'd0, 32'd2004, 1'b0, 32'h8000_0400);
        rd_chk("stat_ovf_clr", 5'd0, 32'd2004, 1'b0, 32'h0000_0400);
        repeat (5) cyc(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("drained5", 32'(sb.size()), 32'd0);

        // full FIFO with a pop and a push in the same cycle
        for (int i = 0; i < 4; i++) st(32'h200 + i, 1'b0);
        st(32'h2FF, 1'b1);
        rd_chk("stat_full_pp", 5'd0, 32'd2004, 1'b0, 32'h0000_0400);
        repeat (5) cyc(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);

        // store to another address is ignored
        cyc(5'd0, 32'd2008, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        rd_chk("stat_ignored", 5'd0, 32'd2004, 1'b0, 32'h0);

        // reset mid-drain
        st(32'h300, 1'b0); st(32'h301, 1'b0);
        cyc(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_data", out_data, 32'd0);
        sb.delete();
        repeat (2) cyc(5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        rd_chk("midrst_stat", 5'd0, 32'd2004, 1'b0, 32'h0);

`ifdef IO_EVENT_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            cyc(5'b01000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            cyc(5'b00000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        end
        rd_chk("stat_cnt_nz", 5'd0, 32'd2004, 1'b0, 32'h08);
        rd_chk("cnt_sat", 5'd0, 32'd5000, 1'b0, 32'd255);
        rd_chk("cnt_clr", 5'd0, 32'd5000, 1'b0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_event_controller.md
Name: io_event_controller

Overview:
- Memory-mapped I/O controller between the processor data-memory port, the five debounced push-buttons and the VGA controller.
- Converts button presses into sticky, read-to-clear event flags at fixed load addresses.
- Queues processor stores to the output address in a small FIFO drained to the VGA block with a valid/ready handshake.
- Exposes a status word with FIFO occupancy and an overflow flag.

Parameters:
- ADDR_BTNC, 1000, load address of centre-button event
- ADDR_OUT, 2000, store address of output mailbox
- ADDR_BTNL, 3000, load address of left-button event
- ADDR_BTNR, 4000, load address of right-button event
- ADDR_BTNU, 5000, load address of up-button event
- ADDR_BTND, 6000, load address of down-button event
- ADDR_STAT, 2004, load address of status word
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
- COUNT_W, 8, event counter width; used only with the optional feature

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- btn_in  in  5  debounced buttons, bit order {D,U,R,L,C}
- mem_addr  in  32  processor data address
- mem_wren  in  1  store strobe, one cycle per store instruction
- mem_rden  in  1  load strobe, one cycle per load instruction
- mem_wdata  in  32  store data
- io_hit  out  1  mem_rden=1 and mem_addr matches any load address above
- io_rdata  out  32  read data; combinational from current state
- out_data  out  32  FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  VGA side consumes the head when out_valid & out_ready

Behaviour:
- Reset, while reset=0:
  - all event flags cleared; previous-button register cleared
  - FIFO emptied; overflow flag cleared
  - out_valid=0, out_data=0
  - io_hit and io_rdata follow their combinational definitions
- Edge detection:
  - prev <= btn_in every cycle
  - rise[i] = btn_in[i] & ~prev[i]
  - a button held high at reset release produces one event
- Event flag i:
  - set on rise[i]
  - cleared at the edge ending a cycle with mem_rden and mem_addr equal to its address
  - rise in the same cycle as the clearing read: flag ends set; the read returns the pre-edge value
- Button read: io_rdata = {31'b0, flag}. Same-cycle, zero-latency response.
- Status read, io_rdata:
  - bits 4:0 = flags {D,U,R,L,C}
  - bits 15:8 = FIFO count
  - bit 31 = overflow
  - all other bits 0
  - the status read clears overflow only, not the event flags
- io_rdata = 0 when there is no hit.
- Push: mem_wren with mem_addr==ADDR_OUT.
  - accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle
  - otherwise the data is dropped and overflow <= 1
  - overflow set and a clearing status read in the same cycle: overflow ends 1
- Pop: out_valid & out_ready.
- Simultaneous push and pop:
  - count unchanged; order preserved
  - when the FIFO is empty no pop occurs, so the push alone proceeds
- Pointers wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
- out_data is registered FIFO head storage:
  - a push into an empty FIFO appears on out_data/out_valid the next cycle (1-cycle latency)
- Stores to other addresses are ignored. mem_wren and mem_rden both asserted: treat as store only.
- Reset asserted mid-operation: the FIFO content is discarded immediately; no partial handshake completes.

Optional Feature:
- Macro: IO_EVENT_COUNT_EN.
- Defined:
  - each button keeps a COUNT_W-bit counter instead of a flag, incremented on rise[i] and saturating at all-ones
  - a button read returns the zero-extended count, then the counter becomes 0, or 1 if rise[i] occurs in the same cycle
  - status bits 4:0 report count!=0
- Undefined: single-bit flags as above; no counters synthesized.

Test Plan:
- Reset release, then pulse btn_in[0] (BTNC) 0->1 for 3 cycles:
  - read 1000 -> io_hit=1, io_rdata=1
  - next read 1000 -> io_rdata=0
- btn_in[1] (BTNL) rising edge in the same cycle as a read of 3000 with the flag already set:
  - io_rdata=1; the following read 3000 returns 1
  - the read after that returns 0
- Store 0xA, 0xB, 0xC to 2000 with out_ready=0:
  - status read shows count=3
  - raise out_ready -> out_data 0xA, 0xB, 0xC on consecutive cycles, then out_valid=0
- Store 5 words with out_ready=0 (DEPTH 4):
  - status = 0x8000_0400
  - second status read = 0x0000_0400
  - fifth word never appears
- FIFO full with out_ready=1 and a store in the same cycle: the push is accepted, count stays 4, overflow stays 0.
- With IO_EVENT_COUNT_EN, COUNT_W=8:
  - 300 BTNU rising edges, then read 5000 -> 255
  - next read -> 0
- Assert reset=0 mid-drain with 2 entries queued: out_valid drops to 0 immediately, status=0 after release.
